// File: rtl/modulo_exp_ctrl_pkg.sv
// Shared definitions for the modular exponentiation sequencer: operand width
// and the controller state encoding.
package modulo_exp_ctrl_pkg;

  localparam int MAX_BITS = 256;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SCAN      = 3'd1,
    ST_SQ_ISSUE  = 3'd2,
    ST_SQ_WAIT   = 3'd3,
    ST_MUL_ISSUE = 3'd4,
    ST_MUL_WAIT  = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

endpackage

// File: rtl/modulo_exp_ctrl.sv
// Left-to-right binary exponentiation sequencer: computes base^e mod n by
// issuing square/multiply jobs to one shared modular multiplier.
module modulo_exp_ctrl
  import modulo_exp_ctrl_pkg::*;
#(
  parameter int EXP_BITS = 256
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [MAX_BITS-1:0] i_n,
  input  logic [MAX_BITS-1:0] i_base,
  input  logic [EXP_BITS-1:0] i_exp,
  output logic [MAX_BITS-1:0] o_result,
  output logic                o_finished,
  output logic                o_busy,
  output logic                o_mul_start,
  output logic [MAX_BITS-1:0] o_mul_a,
  output logic [MAX_BITS-1:0] o_mul_b,
  output logic [MAX_BITS-1:0] o_mul_n,
  input  logic [MAX_BITS-1:0] i_mul_result,
  input  logic                i_mul_finished
);

  localparam int IDX_W = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_BITS - 1);

  state_t state, state_nx;

  logic [MAX_BITS-1:0] n_q, base_q;
  logic [EXP_BITS-1:0] exp_q;
  logic [MAX_BITS-1:0] r, r_nx;
  logic [IDX_W-1:0]    idx, idx_nx;
  logic                seen_one, seen_one_nx;
  logic                accept;

  logic [MAX_BITS-1:0] result_nx, mul_a_nx, mul_b_nx, mul_n_nx;
  logic                finished_nx, busy_nx, mul_start_nx;

  logic bit_cur;
  logic last_bit;
  assign bit_cur  = exp_q[idx];
  assign last_bit = (idx == '0);

  always_comb begin
    state_nx    = state;
    r_nx        = r;
    idx_nx      = idx;
    seen_one_nx = seen_one;
    accept      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_start) begin
          accept      = 1'b1;
          state_nx    = ST_SCAN;
          idx_nx      = IDX_TOP;
          r_nx        = MAX_BITS'(1);
          seen_one_nx = 1'b0;
        end
      end
      ST_SCAN: begin
        if (seen_one) begin
          state_nx = ST_SQ_ISSUE;
        end else begin
          // Leading zeros are skipped; the first one loads r without a job.
          if (bit_cur) begin
            r_nx        = base_q;
            seen_one_nx = 1'b1;
          end
          if (last_bit) state_nx = ST_DONE;
          else          idx_nx   = idx - 1'b1;
        end
      end
      ST_SQ_ISSUE:  state_nx = ST_SQ_WAIT;
      ST_SQ_WAIT: begin
        if (i_mul_finished) begin
          r_nx = i_mul_result;
          if (bit_cur)       state_nx = ST_MUL_ISSUE;
          else if (last_bit) state_nx = ST_DONE;
          else begin
            state_nx = ST_SCAN;
            idx_nx   = idx - 1'b1;
          end
        end
      end
      ST_MUL_ISSUE: state_nx = ST_MUL_WAIT;
      ST_MUL_WAIT: begin
        if (i_mul_finished) begin
          r_nx = i_mul_result;
          if (last_bit) state_nx = ST_DONE;
          else begin
            state_nx = ST_SCAN;
            idx_nx   = idx - 1'b1;
          end
        end
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase

    // Outputs are derived from the next state so they register in step with it;
    // operands stay frozen through the WAIT states while the multiplier scans A.
    result_nx    = o_result;
    mul_a_nx     = o_mul_a;
    mul_b_nx     = o_mul_b;
    mul_n_nx     = o_mul_n;
    mul_start_nx = 1'b0;
    finished_nx  = (state_nx == ST_DONE);
    busy_nx      = (state_nx != ST_IDLE);
    if (state_nx == ST_DONE) result_nx = r_nx;
    if (state_nx == ST_SQ_ISSUE) begin
      mul_start_nx = 1'b1;
      mul_a_nx     = r_nx;
      mul_b_nx     = r_nx;
      mul_n_nx     = n_q;
    end else if (state_nx == ST_MUL_ISSUE) begin
      mul_start_nx = 1'b1;
      mul_a_nx     = r_nx;
      mul_b_nx     = base_q;
      mul_n_nx     = n_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= ST_IDLE;
      r           <= MAX_BITS'(1);
      idx         <= IDX_TOP;
      seen_one    <= 1'b0;
      o_result    <= '0;
      o_finished  <= 1'b0;
      o_busy      <= 1'b0;
      o_mul_start <= 1'b0;
      o_mul_a     <= '0;
      o_mul_b     <= '0;
      o_mul_n     <= '0;
    end else begin
      state       <= state_nx;
      r           <= r_nx;
      idx         <= idx_nx;
      seen_one    <= seen_one_nx;
      o_result    <= result_nx;
      o_finished  <= finished_nx;
      o_busy      <= busy_nx;
      o_mul_start <= mul_start_nx;
      o_mul_a     <= mul_a_nx;
      o_mul_b     <= mul_b_nx;
      o_mul_n     <= mul_n_nx;
    end
  end

  // Operand snapshot taken only when a start is accepted.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      n_q    <= i_n;
      base_q <= i_base;
      exp_q  <= i_exp;
    end
  end

endmodule

// File: doc/modulo_exp_ctrl.md
Name: modulo_exp_ctrl

Overview:
Sequencer that computes base^e mod n by issuing square and multiply jobs to one shared ModuloProduct instance over its start/finished handshake.
Uses left-to-right binary exponentiation.
Sits between the ECC/RSA top-level control and the modular-product datapath. Owns the multiplier's operand and start lines while busy.

Parameters:
EXP_BITS, 256, exponent width; bits scanned MSB-first.
`MAX_BITS (from ECCDefine.vh), 256, operand/modulus width; shared define, not overridable here.

Ports:
i_clk  in  1  clock, rising-edge.
i_rst  in  1  reset, asynchronous, active-low.
i_start  in  1  start pulse; sampled only in IDLE.
i_n  in  MAX_BITS  modulus; caller guarantees n >= 2.
i_base  in  MAX_BITS  base; caller guarantees base < n.
i_exp  in  EXP_BITS  exponent.
o_result  out  MAX_BITS  base^e mod n; valid while o_finished=1, held until next start.
o_finished  out  1  one-cycle done pulse.
o_busy  out  1  high from the cycle after accepted start through the DONE cycle.
o_mul_start  out  1  one-cycle start pulse to the multiplier.
o_mul_a  out  MAX_BITS  multiplier operand A (bit-scanned by the multiplier).
o_mul_b  out  MAX_BITS  multiplier operand B.
o_mul_n  out  MAX_BITS  modulus to the multiplier.
i_mul_result  in  MAX_BITS  multiplier product.
i_mul_finished  in  1  multiplier done pulse.

Behaviour:
- Reset (async, i_rst=0): state IDLE; o_result=0, o_finished=0, o_busy=0, o_mul_start=0, o_mul_a/b/n=0, internal r=1, bit index=EXP_BITS-1, seen_one=0.
- Reset mid-operation aborts immediately with no completion pulse. The multiplier shares i_rst.
- On start, i_n, i_base and i_exp are latched. Inputs may change afterwards. i_start while busy is ignored.
- States: IDLE, SCAN, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, DONE.
- IDLE --i_start--> SCAN with idx=EXP_BITS-1, r=1, seen_one=0.
- SCAN handles one cycle per bit, using e[idx]:
  - seen_one=0 and bit=0: no op.
  - seen_one=0 and bit=1: r=base, seen_one=1, no multiply.
  - seen_one=1: go to SQ_ISSUE.
  - After a no-op or first-one bit: if idx=0, go to DONE; else idx-- and stay in SCAN.
- SQ_ISSUE: o_mul_a=r, o_mul_b=r, o_mul_n=n; o_mul_start=1 for exactly this cycle; then SQ_WAIT.
- SQ_WAIT: operands held stable, since the multiplier reads o_mul_a bits during its run. On i_mul_finished, r=i_mul_result. Then:
  - bit=1: go to MUL_ISSUE.
  - bit=0: go to DONE if idx=0; else idx-- and back to SCAN.
- MUL_ISSUE: o_mul_a=r, o_mul_b=base; start pulse; then MUL_WAIT.
- MUL_WAIT: on finished, r=i_mul_result. Then DONE if idx=0; else idx-- and back to SCAN.
- DONE: o_result=r; o_finished=1 for one cycle; o_busy=1. Next cycle returns to IDLE.
- e=0: result 1 (n>=2). Latency is 1+EXP_BITS scan cycles plus DONE, with zero multiplier jobs.
- Job count: squares = number of bits below the MSB one; multiplies = popcount(e)-1.
- Latency-agnostic: waits any number of cycles for i_mul_finished; no timeout.
- i_mul_finished outside the WAIT states is ignored.
- o_mul_start is never asserted outside ISSUE states and never twice per job.
- All outputs are registered.

Decomposition:
- Shared ECCDefine.vh: `MAX_BITS and a new 3-bit state encoding for this controller.
- Sub-module: none required. The bench instantiates modulo_exp_ctrl with ModuloProduct as the shared resource (top wrapper modulo_exp_top).
- Optional: a split-out exponent bit-scanner (exp_bit_scanner) holding idx/seen_one.

Test Plan:
- EXP_BITS=8, n=13, base=5, e=3 -> o_result=8; 1 square + 1 multiply; exactly 2 o_mul_start pulses; one o_finished pulse.
- n=13, base=5, e=12 (Fermat) -> o_result=1; 3 squares + 1 multiply = 4 jobs.
- e=0 -> o_result=1 with zero mul jobs. e=1, base=7, n=13 -> o_result=7 with zero jobs.
- Pulse i_start and change i_base mid-run; inject a spurious i_mul_finished during SCAN -> result unchanged; extra start not accepted; job count unchanged.
- Assert i_rst=0 during SQ_WAIT -> all outputs 0 asynchronously. A fresh start after release, n=13, base=5, e=3 -> 8.
- Full width: n = secp256k1 p, random base < p, e = p-1 -> o_result=1. Cross-check against the bench reference model.
